// File: rtl/piso_serializer.sv
// piso_serializer: parallel-in, serial-out transmitter.
//
// Accepts a WIDTH-bit word through a valid/ready load handshake and emits it
// one bit per enabled clock on q, MSB-first (drive=0) or LSB-first (drive=1).
// Bit order matches the drive encoding of the serial-in receiver.
//
// Optional feature macro: PISO_PARITY_BIT_EN
//   defined   -> an even-parity bit (XOR of the captured word) follows the
//                last data bit, so a word takes WIDTH+1 bits.
//   undefined -> WIDTH bits per word, no parity logic.
//
// Ports:
//   clk         clock, rising edge
//   rst_n       asynchronous reset, active HIGH (name kept for compatibility)
//   din         parallel word, sampled on an accepted load
//   drive       bit order, sampled with din (0 = MSB-first, 1 = LSB-first)
//   load_valid  source presents a word
//   load_ready  block can accept a word (IDLE only)
//   enable      advance one bit per clock; low stalls all state in SHIFT
//   q           serial data out
//   q_valid     q carries a data or parity bit
//   busy        high in SHIFT
//   done        one-cycle pulse after the last bit has been consumed
module piso_serializer #(
  parameter int unsigned WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] din,
  input  logic             drive,
  input  logic             load_valid,
  output logic             load_ready,
  input  logic             enable,
  output logic             q,
  output logic             q_valid,
  output logic             busy,
  output logic             done
);

`ifdef PISO_PARITY_BIT_EN
  localparam int unsigned TOTAL = WIDTH + 1;
`else
  localparam int unsigned TOTAL = WIDTH;
`endif
  localparam int unsigned CW = $clog2(WIDTH + 1) + 1;

  typedef enum logic {
    IDLE  = 1'b0,
    SHIFT = 1'b1
  } state_t;

  state_t           state;
  state_t           state_nx;
  logic [WIDTH-1:0] sh;
  logic [CW-1:0]    cnt;
  logic             dir;
  logic             done_r;
  logic             accept;
  logic             step;
  logic             last;
  logic             data_bit;
`ifdef PISO_PARITY_BIT_EN
  logic             par;
`endif

  assign accept   = load_valid && (state == IDLE);
  assign step     = (state == SHIFT) && enable;
  assign last     = (cnt == CW'(TOTAL - 1));
  // The current bit always sits at the end the register shifts toward.
  assign data_bit = dir ? sh[0] : sh[WIDTH-1];

  always_ff @(posedge clk or posedge rst_n) begin
    if (rst_n) begin
      state <= IDLE;
    end else begin
      state <= state_nx;
    end
  end

  always_comb begin
    state_nx = state;
    case (state)
      IDLE:    if (load_valid)      state_nx = SHIFT;
      SHIFT:   if (enable && last)  state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst_n) begin
    if (rst_n) begin
      sh     <= '0;
      cnt    <= '0;
      dir    <= 1'b0;
      done_r <= 1'b0;
`ifdef PISO_PARITY_BIT_EN
      par    <= 1'b0;
`endif
    end else begin
      done_r <= step && last;
      if (accept) begin
        sh  <= din;
        dir <= drive;
        cnt <= '0;
`ifdef PISO_PARITY_BIT_EN
        par <= ^din;
`endif
      end else if (step && !last) begin
        cnt <= cnt + 1'b1;
        if (dir) begin
          sh <= {1'b0, sh[WIDTH-1:1]};
        end else begin
          sh <= {sh[WIDTH-2:0], 1'b0};
        end
      end
    end
  end

  always_comb begin
    load_ready = 1'b0;
    busy       = 1'b0;
    q_valid    = 1'b0;
    q          = 1'b0;
    done       = done_r;
    if (state == IDLE) begin
      load_ready = 1'b1;
    end else begin
      busy    = 1'b1;
      q_valid = 1'b1;
`ifdef PISO_PARITY_BIT_EN
      q = (cnt == CW'(WIDTH)) ? par : data_bit;
`else
      q = data_bit;
`endif
    end
  end

endmodule

// File: tb/tb_piso_serializer.sv
// tb_piso_serializer: directed self-checking bench for piso_serializer
// (WIDTH=8). Follows the parity build when PISO_PARITY_BIT_EN is defined.
module tb_piso_serializer;

`ifdef PISO_PARITY_BIT_EN
  localparam int PAR = 1;
`else
  localparam int PAR = 0;
`endif

  logic       clk = 1'b0;
  logic       rst_n;
  logic [7:0] din;
  logic       drive;
  logic       load_valid;
  logic       load_ready;
  logic       enable;
  logic       q;
  logic       q_valid;
  logic       busy;
  logic       done;

  int total = 0;
  int bad   = 0;

  piso_serializer #(.WIDTH(8)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .din        (din),
    .drive      (drive),
    .load_valid (load_valid),
    .load_ready (load_ready),
    .enable     (enable),
    .q          (q),
    .q_valid    (q_valid),
    .busy       (busy),
    .done       (done)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic idle_chk(input string tag);
    chk({tag, ".q"},          32'(q),          32'd0);
    chk({tag, ".q_valid"},    32'(q_valid),    32'd0);
    chk({tag, ".busy"},       32'(busy),       32'd0);
    chk({tag, ".load_ready"}, 32'(load_ready), 32'd1);
  endtask

  // Present a word for exactly one accepting edge.
  task automatic do_load(input logic [7:0] d, input logic dr);
    din        = d;
    drive      = dr;
    load_valid = 1'b1;
    tick();
    load_valid = 1'b0;
  endtask

  // Called right after the accepting edge. seq lists the data bits in send
  // order, leftmost first; in the parity build ^d follows as a ninth bit.
  // The bench stalls for stall_len cycles while bit stall_after is shown.
  task automatic shift_check(input logic [7:0] d, input logic [7:0] seq,
                             input int stall_after, input int stall_len,
                             input string tag);
    int   n    = 8 + PAR;
    int   vcnt = 0;
    logic exp_b;
    for (int i = 0; i < n; i++) begin
      exp_b = (i < 8) ? seq[7-i] : ^d;
      chk($sformatf("%s.bit%0d", tag, i), 32'(q), 32'(exp_b));
      chk($sformatf("%s.qv%0d", tag, i), 32'(q_valid), 32'd1);
      if (q_valid) vcnt++;
      if (i == stall_after && stall_len > 0) begin
        enable = 1'b0;
        for (int s = 0; s < stall_len; s++) begin
          tick();
          chk($sformatf("%s.hold%0d", tag, s), 32'(q), 32'(exp_b));
          if (q_valid) vcnt++;
        end
        enable = 1'b1;
      end
      tick();
    end
    chk({tag, ".done"}, 32'(done), 32'd1);
    idle_chk({tag, ".end"});
    chk({tag, ".qv_cycles"}, 32'(vcnt), 32'(n + stall_len));
  endtask

  initial begin
    rst_n      = 1'b1;
    din        = '0;
    drive      = 1'b0;
    load_valid = 1'b0;
    enable     = 1'b1;
    tick();
    tick();
    rst_n = 1'b0;
    tick();
    idle_chk("reset");
    chk("reset.done", 32'(done), 32'd0);

    // A5 MSB-first, then verify done is a single-cycle pulse.
    do_load(8'hA5, 1'b0);
    chk("a5m.busy", 32'(busy), 32'd1);
    chk("a5m.ready", 32'(load_ready), 32'd0);
    shift_check(8'hA5, 8'b1010_0101, -1, 0, "a5m");
    tick();
    chk("a5m.done_clear", 32'(done), 32'd0);

    // LSB-first words.
    do_load(8'hA5, 1'b1);
    shift_check(8'hA5, 8'b1010_0101, -1, 0, "a5l");
    do_load(8'h01, 1'b1);
    shift_check(8'h01, 8'b1000_0000, -1, 0, "01l");

    // Stall three cycles while bit 2 is presented.
    do_load(8'hF0, 1'b0);
    shift_check(8'hF0, 8'b1111_0000, 2, 3, "f0s");

    // Loads during SHIFT are ignored, and a drive change has no effect.
    // load_valid stays high into the done cycle, where FF is accepted.
    do_load(8'h6C, 1'b0);
    din        = 8'hFF;
    drive      = 1'b1;
    load_valid = 1'b1;
    shift_check(8'h6C, 8'b0110_1100, -1, 0, "ign");
    do_load(8'hFF, 1'b0);
    chk("b2b.busy", 32'(busy), 32'd1);
    shift_check(8'hFF, 8'b1111_1111, -1, 0, "b2b");
    tick();

    // Asynchronous reset while bit 4 of 3C is on q.
    do_load(8'h3C, 1'b0);
    for (int i = 0; i < 4; i++) tick();
    chk("rst.pre_q", 32'(q), 32'd1);
    #2 rst_n = 1'b1;
    #1;
    idle_chk("rst.async");
    chk("rst.done", 32'(done), 32'd0);
    tick();
    rst_n = 1'b0;
    tick();
    chk("rst.no_done", 32'(done), 32'd0);
    do_load(8'h81, 1'b0);
    shift_check(8'h81, 8'b1000_0001, -1, 0, "81m");
    tick();

`ifdef PISO_PARITY_BIT_EN
    do_load(8'h07, 1'b0);
    shift_check(8'h07, 8'b0000_0111, -1, 0, "p07");
    chk("p07.par", 32'(^8'h07), 32'd1);
    do_load(8'h03, 1'b0);
    shift_check(8'h03, 8'b0000_0011, -1, 0, "p03");
    tick();
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
